parity_frame_sequencer: RTL and testbench

//  Sequences even-parity checking over a frame of bytes, each carrying its own parity bit.

---
 rtl/parity_frame_sequencer.sv | 123 ++++++++++++
 tb/tb_parity_frame_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_sequencer.sv
// ---------------------------------------------------------------------------
// parity_frame_sequencer
//
// Checks even parity over a frame of bytes and reports a summary for each
// frame. A frame starts when start is seen in IDLE, and frame_len sets how
// many bytes it holds. The bytes then arrive on a valid/ready stream, each
// byte with its own parity bit. When the last byte has been taken, the block
// gives a one-cycle done pulse. The summary outputs (error flag, saturating
// error count and index of the first bad byte) keep their values until the
// next accepted start clears them.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   start          begin a frame; only looked at in IDLE
//   frame_len      number of bytes in the frame; sampled with start
//   in_valid       byte beat valid
//   in_ready       block accepts a beat (high only while running)
//   in_data        byte to check
//   in_parity      even-parity bit sent with in_data
//   busy           high while a frame is running or its summary is out
//   done           one-cycle pulse: summary outputs are valid
//   frame_err      at least one byte of the last frame failed parity
//   err_count      failing bytes in the last frame, saturating at all-ones
//   first_err_idx  0-based index of the first failing byte, 0 if none
// ---------------------------------------------------------------------------
module parity_frame_sequencer #(
   parameter int DATA_W   = 8,
   parameter int LEN_W    = 8,
   parameter int ERRCNT_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [LEN_W-1:0]    frame_len,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_W-1:0]   in_data,
   input  logic                in_parity,
   output logic                busy,
   output logic                done,
   output logic                frame_err,
   output logic [ERRCNT_W-1:0] err_count,
   output logic [LEN_W-1:0]    first_err_idx
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [LEN_W-1:0]    LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
   localparam logic [ERRCNT_W-1:0] ERR_ONE = {{(ERRCNT_W-1){1'b0}}, 1'b1};

   state_t             state;
   logic [LEN_W-1:0]   len;
   logic [LEN_W-1:0]   idx;
   logic               bad;

   // A byte is bad when its data bits plus its parity bit hold an odd
   // number of ones.
   assign bad = (^in_data) ^ in_parity;

   // The handshake and status outputs come straight from the state register.
   // So in_ready never depends combinationally on any input.
   assign in_ready = (state == RUN);
   assign busy     = (state != IDLE);
   assign done     = (state == DONE);

   // Frame sequencer and summary accumulation.
   // idx only has to count up to len-1, and len is at most 2**LEN_W-1.
   // The terminal compare therefore happens before idx could wrap.
   // frame_err doubles as the "a failure was already seen" flag. This keeps
   // first_err_idx pointing at the earliest bad byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         len           <= '0;
         idx           <= '0;
         frame_err     <= 1'b0;
         err_count     <= '0;
         first_err_idx <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  len           <= frame_len;
                  idx           <= '0;
                  frame_err     <= 1'b0;
                  err_count     <= '0;
                  first_err_idx <= '0;
                  state         <= (frame_len == '0) ? DONE : RUN;
               end
            end
            RUN: begin
               if (in_valid) begin
                  idx <= idx + LEN_ONE;
                  if (bad) begin
                     frame_err <= 1'b1;
                     if (err_count != '1) begin
                        err_count <= err_count + ERR_ONE;
                     end
                     if (!frame_err) begin
                        first_err_idx <= idx;
                     end
                  end
                  if (idx == len - LEN_ONE) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_parity_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_parity_frame_sequencer
//
// Scoreboard bench for parity_frame_sequencer. Each frame is built as a list
// of bytes. A reference model counts the ones in every byte to work out the
// expected summary, and that summary is queued when the frame is issued.
// A monitor process watches the DUT, counts accepted beats and checks each
// done pulse against the oldest queued summary.
// ---------------------------------------------------------------------------
module tb_parity_frame_sequencer;

   localparam int DATA_W   = 8;
   localparam int LEN_W    = 8;
   localparam int ERRCNT_W = 4;
   localparam int ERR_SAT  = (1 << ERRCNT_W) - 1;

   logic                clk;
   logic                rst;
   logic                start;
   logic [LEN_W-1:0]    frame_len;
   logic                in_valid;
   logic                in_ready;
   logic [DATA_W-1:0]   in_data;
   logic                in_parity;
   logic                busy;
   logic                done;
   logic                frame_err;
   logic [ERRCNT_W-1:0] err_count;
   logic [LEN_W-1:0]    first_err_idx;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              parity;
   } beat_t;

   typedef struct {
      int len;
      int ferr;
      int ecnt;
      int fidx;
   } exp_t;

   beat_t frameBytes[$];
   exp_t  expQ[$];

   int compared   = 0;
   int mismatched = 0;
   int negCycle   = 0;
   int acceptCnt  = 0;
   int lastEvent  = 0;
   bit prevDone   = 0;

   parity_frame_sequencer #(
      .DATA_W   (DATA_W),
      .LEN_W    (LEN_W),
      .ERRCNT_W (ERRCNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .frame_len     (frame_len),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .in_parity     (in_parity),
      .busy          (busy),
      .done          (done),
      .frame_err     (frame_err),
      .err_count     (err_count),
      .first_err_idx (first_err_idx)
   );

   // Free-running 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point. Every check in the bench goes through here.
   task automatic checkOutput(input string name, input int actual, input int required);
      compared++;
      if (actual != required) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, required, $time);
      end
   endtask

   // Add one byte to the frame. The parity bit is set to match or break even
   // parity, based on the number of ones in the byte.
   task automatic addBeat(input logic [DATA_W-1:0] data, input bit wantBad);
      beat_t b;
      int    ones;
      ones     = $countones(data);
      b.data   = data;
      b.parity = wantBad ? logic'(1 - (ones % 2)) : logic'(ones % 2);
      frameBytes.push_back(b);
   endtask

   task automatic addRawBeat(input logic [DATA_W-1:0] data, input logic parity);
      beat_t b;
      b.data   = data;
      b.parity = parity;
      frameBytes.push_back(b);
   endtask

   task automatic addRandomBeats(input int n, input int badPct);
      for (int i = 0; i < n; i++) begin
         addBeat(DATA_W'($urandom), $urandom_range(99) < badPct);
      end
   endtask

   // Reference model: walk the frame in order. A byte fails when its data
   // plus parity hold an odd number of ones.
   function automatic exp_t buildExpected(input int len);
      exp_t e;
      e.len  = len;
      e.ferr = 0;
      e.ecnt = 0;
      e.fidx = 0;
      for (int i = 0; i < len; i++) begin
         if ((($countones(frameBytes[i].data) + int'(frameBytes[i].parity)) % 2) != 0) begin
            if (e.ferr == 0) e.fidx = i;
            e.ferr = 1;
            if (e.ecnt < ERR_SAT) e.ecnt++;
         end
      end
      return e;
   endfunction

   // Issue one frame from frameBytes.
   // Inputs change 1 unit after each rising edge, so they are stable for the
   // whole cycle around the monitor's falling-edge sample.
   // abortAfter >= 0 pulls reset once that many beats have been taken.
   task automatic applyStimulus(input int len, input int validPct,
                                input bit startWhileBusy, input int abortAfter);
      int sent;
      int guard;
      int waitCnt;
      expQ.push_back(buildExpected(len));

      @(posedge clk); #1;
      start     = 1'b1;
      frame_len = LEN_W'(len);
      in_valid  = 1'b0;
      @(posedge clk); #1;
      start     = 1'b0;
      frame_len = LEN_W'($urandom);

      sent  = 0;
      guard = 0;
      while (sent < len && guard < 5000) begin
         if (abortAfter >= 0 && sent == abortAfter) break;
         in_valid  = ($urandom_range(99) < validPct);
         in_data   = frameBytes[sent].data;
         in_parity = frameBytes[sent].parity;
         start     = startWhileBusy && ($urandom_range(3) == 0);
         if (in_valid && in_ready) sent++;
         @(posedge clk); #1;
         guard++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      if (guard >= 5000) checkOutput("beat_timeout", 0, 1);

      if (abortAfter >= 0) begin
         // Reset in the middle of a cycle must clear everything at once.
         #2;
         rst = 1'b1;
         #1;
         checkOutput("abort_busy", busy, 0);
         checkOutput("abort_ready", in_ready, 0);
         checkOutput("abort_done", done, 0);
         checkOutput("abort_frame_err", frame_err, 0);
         checkOutput("abort_err_count", err_count, 0);
         checkOutput("abort_first_idx", first_err_idx, 0);
         void'(expQ.pop_back());
         @(posedge clk); #1;
         rst = 1'b0;
         return;
      end

      waitCnt = 0;
      while (!done && waitCnt < 10) begin
         @(posedge clk); #1;
         waitCnt++;
      end
      if (waitCnt >= 10) checkOutput("done_timeout", 0, 1);
      @(posedge clk); #1;
      checkOutput("idle_after_done", busy, 0);
   endtask

   // Monitor: count beats that will be accepted on the next rising edge.
   // On each done pulse, compare the DUT summary with the oldest queued
   // expectation.
   always @(negedge clk) begin
      exp_t e;
      negCycle++;
      if (rst) begin
         acceptCnt = 0;
         prevDone  = 0;
      end else begin
         if (start && !busy) begin
            acceptCnt = 0;
            lastEvent = negCycle;
         end
         if (in_valid && in_ready) begin
            acceptCnt++;
            lastEvent = negCycle;
         end
         if (done) begin
            checkOutput("done_single_pulse", int'(prevDone), 0);
            checkOutput("done_ready_low", in_ready, 0);
            checkOutput("done_busy_high", busy, 1);
            if (expQ.size() == 0) begin
               checkOutput("unexpected_done", 1, 0);
            end else begin
               e = expQ.pop_front();
               checkOutput("accept_count", acceptCnt, e.len);
               checkOutput("done_latency", negCycle - lastEvent, 1);
               checkOutput("frame_err", frame_err, e.ferr);
               checkOutput("err_count", err_count, e.ecnt);
               checkOutput("first_err_idx", first_err_idx, e.fidx);
            end
         end
         prevDone = done;
      end
   end

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      frame_len = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_parity = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_ready", in_ready, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_frame_err", frame_err, 0);
      checkOutput("reset_err_count", err_count, 0);
      checkOutput("reset_first_idx", first_err_idx, 0);
      rst = 1'b0;

      $display("[TB] clean frame, len 4");
      frameBytes.delete();
      addRawBeat(8'h00, 1'b0);
      addRawBeat(8'h01, 1'b1);
      addRawBeat(8'hFF, 1'b0);
      addRawBeat(8'h7F, 1'b1);
      applyStimulus(4, 100, 0, -1);

      $display("[TB] two bad bytes, len 3");
      frameBytes.delete();
      addRawBeat(8'h03, 1'b1);
      addRawBeat(8'h05, 1'b0);
      addRawBeat(8'h80, 1'b0);
      applyStimulus(3, 100, 0, -1);

      $display("[TB] saturation, len 20 all bad");
      frameBytes.delete();
      addRandomBeats(20, 100);
      applyStimulus(20, 100, 0, -1);

      $display("[TB] zero-length frame");
      frameBytes.delete();
      applyStimulus(0, 100, 0, -1);

      $display("[TB] gapped beats with start while busy, len 5");
      frameBytes.delete();
      addRandomBeats(5, 50);
      applyStimulus(5, 50, 1, -1);

      $display("[TB] reset mid-frame, then len 1");
      frameBytes.delete();
      addRandomBeats(6, 100);
      applyStimulus(6, 100, 0, 2);
      frameBytes.delete();
      addRandomBeats(1, 100);
      applyStimulus(1, 100, 0, -1);

      $display("[TB] random frames");
      for (int n = 0; n < 30; n++) begin
         int len;
         len = $urandom_range(1, 40);
         frameBytes.delete();
         addRandomBeats(len, $urandom_range(0, 60));
         applyStimulus(len, $urandom_range(40, 100), $urandom_range(1), -1);
      end

      $display("[TB] maximum-length frame");
      frameBytes.delete();
      addRandomBeats(255, 100);
      frameBytes[254].parity = ~frameBytes[254].parity;
      frameBytes[3].parity   = ~frameBytes[3].parity;
      frameBytes[0].parity   = ~frameBytes[0].parity;
      applyStimulus(255, 100, 0, -1);

      repeat (5) @(posedge clk);
      #1;
      checkOutput("scoreboard_drained", expQ.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
